// File: rtl/mmio_host_initiator_pkg.sv
// -----------------------------------------------------------------------------
// mmio_host_initiator_pkg
// Shared definitions for the host-side MMIO initiator:
//   - TIA_MMIO_INDEX_WIDTH / TIA_MMIO_DATA_WIDTH : mmio_if word index / data widths
//   - TIA_MMIO_INITIATOR_TIMEOUT_CYCLES          : default acknowledge timeout
//   - mmio_initiator_state_t                     : initiator FSM state encoding
// -----------------------------------------------------------------------------
package mmio_host_initiator_pkg;

    localparam int TIA_MMIO_INDEX_WIDTH              = 8;
    localparam int TIA_MMIO_DATA_WIDTH               = 32;
    localparam int TIA_MMIO_INITIATOR_TIMEOUT_CYCLES = 256;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        READ    = 2'd1,
        WRITE   = 2'd2,
        RESPOND = 2'd3
    } mmio_initiator_state_t;

endpackage

// File: rtl/mmio_if.sv
// -----------------------------------------------------------------------------
// mmio_if
// Single-word MMIO bus between a host initiator and the memory mapper.
//   host modport  : drives read_req/read_index, write_req/write_index/write_data;
//                   receives read_ack/read_data and write_ack.
//   device modport: the mirror image.
// -----------------------------------------------------------------------------
interface mmio_if;
    import mmio_host_initiator_pkg::*;

    logic                            read_req;
    logic [TIA_MMIO_INDEX_WIDTH-1:0] read_index;
    logic                            read_ack;
    logic [TIA_MMIO_DATA_WIDTH-1:0]  read_data;
    logic                            write_req;
    logic [TIA_MMIO_INDEX_WIDTH-1:0] write_index;
    logic [TIA_MMIO_DATA_WIDTH-1:0]  write_data;
    logic                            write_ack;

    modport host (
        output read_req, read_index, write_req, write_index, write_data,
        input  read_ack, read_data, write_ack
    );

    modport device (
        input  read_req, read_index, write_req, write_index, write_data,
        output read_ack, read_data, write_ack
    );
endinterface

// File: rtl/mmio_host_initiator_timeout_counter.sv
// -----------------------------------------------------------------------------
// mmio_timeout_counter
// Counts cycles a request has been outstanding and flags the last allowed one.
//   clock, reset_n : system clock, asynchronous active-low reset
//   clear          : force the count to zero (held while no request is pending)
//   enable         : a request is pending this cycle; count advances
//   expired        : enable is high and this is cycle TIMEOUT_CYCLES of the request
// Parameter TIMEOUT_CYCLES (2..65535). The owner leaves the request state on
// expired, so the count never wraps.
// -----------------------------------------------------------------------------
module mmio_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int            CW   = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Next count: clear wins over enable.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + CW'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = enable && (count_q == LAST);

endmodule

// File: rtl/mmio_host_initiator.sv
// -----------------------------------------------------------------------------
// mmio_host_initiator
// Turns a valid/ready command stream into single mmio_if read or write
// transactions and returns exactly one response per command.
//
// Ports:
//   clock, reset_n           : system clock, asynchronous active-low reset
//   cmd_valid/cmd_ready      : command handshake (cmd_ready is 0 during reset)
//   cmd_write, cmd_index,
//   cmd_data                 : command (1 = write); cmd_data ignored for reads
//   rsp_valid/rsp_ready      : response handshake
//   rsp_data, rsp_error      : read data (0 for writes/errors), timeout flag
//   mmio                     : mmio_if.host towards the memory mapper
//
// Parameter TIMEOUT_CYCLES (2..65535): longest a request is held unanswered.
//
// Build option TIA_MMIO_INITIATOR_TIMEOUT_EN: when defined, a timeout counter
// ends unanswered requests with rsp_error = 1. When undefined the initiator
// waits for an acknowledge indefinitely and rsp_error is always 0.
// -----------------------------------------------------------------------------
module mmio_host_initiator
    import mmio_host_initiator_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIA_MMIO_INITIATOR_TIMEOUT_CYCLES
) (
    input  logic                            clock,
    input  logic                            reset_n,
    input  logic                            cmd_valid,
    output logic                            cmd_ready,
    input  logic                            cmd_write,
    input  logic [TIA_MMIO_INDEX_WIDTH-1:0] cmd_index,
    input  logic [TIA_MMIO_DATA_WIDTH-1:0]  cmd_data,
    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic [TIA_MMIO_DATA_WIDTH-1:0]  rsp_data,
    output logic                            rsp_error,
    mmio_if.host                            mmio
);

    if ((TIMEOUT_CYCLES < 2) || (TIMEOUT_CYCLES > 65535)) begin : g_bad_timeout
        $error("mmio_host_initiator: TIMEOUT_CYCLES must be within 2..65535");
    end

    mmio_initiator_state_t state_q, state_d;

    logic [TIA_MMIO_INDEX_WIDTH-1:0] cap_index_q, cap_index_d;
    logic [TIA_MMIO_DATA_WIDTH-1:0]  cap_data_q, cap_data_d;
    logic                            cmd_ready_q, cmd_ready_d;
    logic                            rsp_valid_q, rsp_valid_d;
    logic [TIA_MMIO_DATA_WIDTH-1:0]  rsp_data_q, rsp_data_d;
    logic                            rsp_error_q, rsp_error_d;
    logic                            read_req_q, read_req_d;
    logic [TIA_MMIO_INDEX_WIDTH-1:0] read_index_q, read_index_d;
    logic                            write_req_q, write_req_d;
    logic [TIA_MMIO_INDEX_WIDTH-1:0] write_index_q, write_index_d;
    logic [TIA_MMIO_DATA_WIDTH-1:0]  write_data_q, write_data_d;
    logic                            expired_s;

`ifdef TIA_MMIO_INITIATOR_TIMEOUT_EN
    logic in_request_s;

    // Held in clear outside READ/WRITE, so every request starts counting from 0.
    assign in_request_s = (state_q == READ) || (state_q == WRITE);

    mmio_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (!in_request_s),
        .enable  (in_request_s),
        .expired (expired_s)
    );
`else
    assign expired_s = 1'b0;
`endif

    // Next-state logic; all registered outputs are decoded from the next state
    // so a request rises the cycle after the handshake and falls together with
    // rsp_valid rising.
    always_comb begin
        state_d     = state_q;
        cap_index_d = cap_index_q;
        cap_data_d  = cap_data_q;
        rsp_data_d  = rsp_data_q;
        rsp_error_d = rsp_error_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    cap_index_d = cmd_index;
                    cap_data_d  = cmd_write ? cmd_data : '0;
                    state_d     = cmd_write ? WRITE : READ;
                end else begin
                    state_d = IDLE;
                end
            end
            READ: begin
                // An acknowledge on the final allowed cycle takes priority.
                if (mmio.read_ack) begin
                    rsp_data_d  = mmio.read_data;
                    rsp_error_d = 1'b0;
                    state_d     = RESPOND;
                end else if (expired_s) begin
                    rsp_data_d  = '0;
                    rsp_error_d = 1'b1;
                    state_d     = RESPOND;
                end else begin
                    state_d = READ;
                end
            end
            WRITE: begin
                if (mmio.write_ack) begin
                    rsp_data_d  = '0;
                    rsp_error_d = 1'b0;
                    state_d     = RESPOND;
                end else if (expired_s) begin
                    rsp_data_d  = '0;
                    rsp_error_d = 1'b1;
                    state_d     = RESPOND;
                end else begin
                    state_d = WRITE;
                end
            end
            RESPOND: begin
                if (rsp_ready) begin
                    rsp_data_d  = '0;
                    rsp_error_d = 1'b0;
                    cap_index_d = '0;
                    cap_data_d  = '0;
                    state_d     = IDLE;
                end else begin
                    state_d = RESPOND;
                end
            end
            default: begin
                state_d     = IDLE;
                rsp_data_d  = '0;
                rsp_error_d = 1'b0;
            end
        endcase

        cmd_ready_d   = (state_d == IDLE);
        rsp_valid_d   = (state_d == RESPOND);
        read_req_d    = (state_d == READ);
        write_req_d   = (state_d == WRITE);
        read_index_d  = read_req_d  ? cap_index_d : '0;
        write_index_d = write_req_d ? cap_index_d : '0;
        write_data_d  = write_req_d ? cap_data_d  : '0;
    end

    // State, capture and output registers; reset drops any pending request at once.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            cap_index_q   <= '0;
            cap_data_q    <= '0;
            cmd_ready_q   <= 1'b1;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= '0;
            rsp_error_q   <= 1'b0;
            read_req_q    <= 1'b0;
            read_index_q  <= '0;
            write_req_q   <= 1'b0;
            write_index_q <= '0;
            write_data_q  <= '0;
        end else begin
            state_q       <= state_d;
            cap_index_q   <= cap_index_d;
            cap_data_q    <= cap_data_d;
            cmd_ready_q   <= cmd_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_data_q    <= rsp_data_d;
            rsp_error_q   <= rsp_error_d;
            read_req_q    <= read_req_d;
            read_index_q  <= read_index_d;
            write_req_q   <= write_req_d;
            write_index_q <= write_index_d;
            write_data_q  <= write_data_d;
        end
    end

    // cmd_ready idles high in IDLE but must read 0 while reset is held.
    assign cmd_ready        = cmd_ready_q & reset_n;
    assign rsp_valid        = rsp_valid_q;
    assign rsp_data         = rsp_data_q;
    assign rsp_error        = rsp_error_q;
    assign mmio.read_req    = read_req_q;
    assign mmio.read_index  = read_index_q;
    assign mmio.write_req   = write_req_q;
    assign mmio.write_index = write_index_q;
    assign mmio.write_data  = write_data_q;

endmodule

// File: tb/tb_mmio_host_initiator.sv
// -----------------------------------------------------------------------------
// tb_mmio_host_initiator
// Self-checking bench for mmio_host_initiator: a table of directed
// transactions, randomized transactions checked against a cycle-count model,
// plus hand-written reset, stray-acknowledge and (build dependent) long-wait /
// timeout sequences. TIA_MMIO_INITIATOR_TIMEOUT_EN selects which apply.
// -----------------------------------------------------------------------------
module tb_mmio_host_initiator;
    import mmio_host_initiator_pkg::*;

    localparam int T = 8;
`ifdef TIA_MMIO_INITIATOR_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic                            clock;
    logic                            reset_n;
    logic                            cmd_valid;
    logic                            cmd_ready;
    logic                            cmd_write;
    logic [TIA_MMIO_INDEX_WIDTH-1:0] cmd_index;
    logic [TIA_MMIO_DATA_WIDTH-1:0]  cmd_data;
    logic                            rsp_valid;
    logic                            rsp_ready;
    logic [TIA_MMIO_DATA_WIDTH-1:0]  rsp_data;
    logic                            rsp_error;

    int tests = 0;
    int fails = 0;

    mmio_if mmio_bus ();

    mmio_host_initiator #(
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_index (cmd_index),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_error (rsp_error),
        .mmio      (mmio_bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic                            wr;
        logic [TIA_MMIO_INDEX_WIDTH-1:0] idx;
        logic [31:0]                     wdata;
        int                              ack_at;   // request cycle carrying the ack
        int                              hold;     // cycles rsp_ready is held low
        logic [31:0]                     rdata;
        int                              exp_cycles;
        logic [31:0]                     exp_data;
        logic                            exp_err;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Reference rules: a request lasts until its ack, capped at T cycles when
    // the timeout exists; an uncapped ack beyond T means a timed-out request.
    function automatic int model_cycles(input int ack_at);
        return (TO_EN && (ack_at > T)) ? T : ack_at;
    endfunction

    function automatic logic model_err(input int ack_at);
        return TO_EN && (ack_at > T);
    endfunction

    function automatic vec_t mk(input logic wr, input logic [TIA_MMIO_INDEX_WIDTH-1:0] idx,
                                input logic [31:0] wdata, input int ack_at, input int hold,
                                input logic [31:0] rdata);
        vec_t v;
        v.wr = wr; v.idx = idx; v.wdata = wdata; v.ack_at = ack_at;
        v.hold = hold; v.rdata = rdata;
        v.exp_cycles = model_cycles(ack_at);
        v.exp_err    = model_err(ack_at);
        v.exp_data   = (wr || v.exp_err) ? 32'd0 : rdata;
        return v;
    endfunction

    task automatic run_txn(input vec_t v, input string tag);
        int n;
        logic active;
        check({tag, ".cmd_ready_idle"}, 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1; cmd_write = v.wr; cmd_index = v.idx; cmd_data = v.wdata;
        rsp_ready = 1'b0;
        step();
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_index = '0; cmd_data = '0;
        if (v.wr) begin
            check({tag, ".write_index"}, 32'(mmio_bus.write_index), 32'(v.idx));
            check({tag, ".write_data"}, mmio_bus.write_data, v.wdata);
            check({tag, ".read_req_off"}, 32'(mmio_bus.read_req), 32'd0);
        end else begin
            check({tag, ".read_index"}, 32'(mmio_bus.read_index), 32'(v.idx));
            check({tag, ".write_req_off"}, 32'(mmio_bus.write_req), 32'd0);
        end
        check({tag, ".cmd_ready_busy"}, 32'(cmd_ready), 32'd0);
        n = 0;
        active = v.wr ? mmio_bus.write_req : mmio_bus.read_req;
        while (active && (n < 2000)) begin
            n++;
            if (n == v.ack_at) begin
                if (v.wr) begin
                    mmio_bus.write_ack = 1'b1;
                end else begin
                    mmio_bus.read_ack  = 1'b1;
                    mmio_bus.read_data = v.rdata;
                end
            end
            step();
            mmio_bus.read_ack = 1'b0; mmio_bus.write_ack = 1'b0; mmio_bus.read_data = '0;
            active = v.wr ? mmio_bus.write_req : mmio_bus.read_req;
        end
        check({tag, ".req_cycles"}, 32'(n), 32'(v.exp_cycles));
        check({tag, ".rsp_valid"}, 32'(rsp_valid), 32'd1);
        check({tag, ".rsp_data"}, rsp_data, v.exp_data);
        check({tag, ".rsp_error"}, 32'(rsp_error), 32'(v.exp_err));
        check({tag, ".bus_idle"},
              {mmio_bus.read_req, mmio_bus.write_req, 30'(mmio_bus.read_index | mmio_bus.write_index)} |
              mmio_bus.write_data, 32'd0);
        for (int h = 0; h < v.hold; h++) begin
            cmd_valid = 1'b1; cmd_write = ~v.wr; cmd_index = ~v.idx;
            step();
            check({tag, ".hold_valid"}, 32'(rsp_valid), 32'd1);
            check({tag, ".hold_data"}, rsp_data, v.exp_data);
            check({tag, ".hold_error"}, 32'(rsp_error), 32'(v.exp_err));
            check({tag, ".hold_cmd_ready"}, 32'(cmd_ready), 32'd0);
            check({tag, ".hold_no_req"}, 32'({mmio_bus.read_req, mmio_bus.write_req}), 32'd0);
        end
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_index = '0;
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check({tag, ".rsp_done"}, 32'(rsp_valid), 32'd0);
        check({tag, ".cmd_ready_back"}, 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ok;
        vec_t v;
        reset_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_index = '0; cmd_data = '0;
        rsp_ready = 1'b0;
        mmio_bus.read_ack = 1'b0; mmio_bus.write_ack = 1'b0; mmio_bus.read_data = '0;

        // Directed table: {wr, idx, wdata, ack_at, hold, rdata} + expected fields.
        vecs.push_back('{1'b0, 8'd5,   32'h0,        3, 0, 32'hDEADBEEF, 3, 32'hDEADBEEF, 1'b0});
        vecs.push_back('{1'b1, 8'd16,  32'h1234,     1, 0, 32'h0,        1, 32'h0,        1'b0});
        vecs.push_back('{1'b0, 8'd7,   32'h0,        2, 5, 32'hA5A50F0F, 2, 32'hA5A50F0F, 1'b0});
        vecs.push_back('{1'b1, 8'd255, 32'hFFFFFFFF, 4, 1, 32'h0,        4, 32'h0,        1'b0});
`ifdef TIA_MMIO_INITIATOR_TIMEOUT_EN
        vecs.push_back('{1'b0, 8'd9,   32'h0,        9, 0, 32'h11112222, 8, 32'h0,        1'b1});
        vecs.push_back('{1'b0, 8'd9,   32'h0,        8, 0, 32'h33334444, 8, 32'h33334444, 1'b0});
        vecs.push_back('{1'b1, 8'd200, 32'h55AA55AA, 50, 2, 32'h0,       8, 32'h0,        1'b1});
`endif

        // Reset state.
        step(); step();
        check("reset.cmd_ready", 32'(cmd_ready), 32'd0);
        check("reset.rsp", {rsp_valid, rsp_error, 30'd0} | rsp_data, 32'd0);
        check("reset.bus", {mmio_bus.read_req, mmio_bus.write_req, 30'd0} | mmio_bus.write_data |
              32'(mmio_bus.read_index) | 32'(mmio_bus.write_index), 32'd0);
        reset_n = 1'b1;
        step();
        check("reset.cmd_ready_after", 32'(cmd_ready), 32'd1);

        foreach (vecs[i]) run_txn(vecs[i], $sformatf("vec%0d", i));

        // Acknowledges while idle are ignored.
        mmio_bus.read_ack = 1'b1; mmio_bus.write_ack = 1'b1; mmio_bus.read_data = 32'hCAFE;
        ok = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (!rsp_valid && cmd_ready && !mmio_bus.read_req && !mmio_bus.write_req) ok++;
        end
        mmio_bus.read_ack = 1'b0; mmio_bus.write_ack = 1'b0; mmio_bus.read_data = '0;
        check("idle_ack.ignored", 32'(ok), 32'd3);

        // Reset in the middle of a read.
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_index = 8'd3;
        step();
        cmd_valid = 1'b0; cmd_index = '0;
        step();
        check("rst_mid.read_req_before", 32'(mmio_bus.read_req), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("rst_mid.read_req_drop", 32'(mmio_bus.read_req), 32'd0);
        check("rst_mid.rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_mid.cmd_ready", 32'(cmd_ready), 32'd0);
        step(); step();
        reset_n = 1'b1;
        step();
        check("rst_mid.cmd_ready_after", 32'(cmd_ready), 32'd1);
        rsp_ready = 1'b1; mmio_bus.read_ack = 1'b1;
        ok = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (!rsp_valid && !mmio_bus.read_req) ok++;
        end
        rsp_ready = 1'b0; mmio_bus.read_ack = 1'b0;
        check("rst_mid.no_stale_rsp", 32'(ok), 32'd4);

`ifndef TIA_MMIO_INITIATOR_TIMEOUT_EN
        // Without the timeout the request waits for an acknowledge indefinitely.
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_index = 8'd42;
        step();
        cmd_valid = 1'b0; cmd_index = '0;
        ok = 0;
        for (int i = 0; i < 1000; i++) begin
            if (mmio_bus.read_req && !rsp_valid && !rsp_error) ok++;
            step();
        end
        check("no_timeout.held_1000", 32'(ok), 32'd1000);
        mmio_bus.read_ack = 1'b1; mmio_bus.read_data = 32'h0BADF00D;
        step();
        mmio_bus.read_ack = 1'b0; mmio_bus.read_data = '0;
        check("no_timeout.rsp_data", rsp_data, 32'h0BADF00D);
        check("no_timeout.rsp_valid", 32'(rsp_valid), 32'd1);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
`endif

        // Randomized transactions against the model.
        for (int i = 0; i < 40; i++) begin
            v = mk(1'($urandom_range(1, 0)), 8'($urandom()), $urandom(),
                   int'($urandom_range(TO_EN ? 11 : 6, 1)), int'($urandom_range(3, 0)),
                   $urandom());
            run_txn(v, $sformatf("rnd%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
